// File: rtl/result_display_pkg.sv
// Shared FSM encoding, seven-segment codes and the double-dabble nibble adjust.
package result_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_UPDATE  = 2'd2
    } state_e;

    localparam int BCD_W = 12;

    // Segments gfedcba, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int n = 0; n < BCD_W / 4; n++) begin
            if (r[n*4 +: 4] >= 4'd5)
                r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/result_display_bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module bcd_to_seg7
    import result_display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display.sv
// Binary-to-BCD converter (double-dabble) driving a 3-digit multiplexed
// seven-segment display with leading-zero blanking.
module result_display
    import result_display_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int SCANDIV   = 12500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] DataIn,
    input  logic                 load,
    output logic                 busy,
    output logic                 done,
    output logic [6:0]           sSeg,
    output logic [3:0]           sAnode
);

    localparam int CNT_W  = $clog2(DATAWIDTH + 1);
    localparam int SCAN_W = (SCANDIV > 1) ? $clog2(SCANDIV) : 1;

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] sr_q, sr_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           units_q, units_d, tens_q, tens_d, hund_q, hund_d;
    logic                 done_q, done_d;
    logic                 load_q;

    logic [SCAN_W-1:0]    scan_q, scan_d;
    logic [1:0]           idx_q, idx_d;
    logic [3:0]           slot_digit;
    logic                 slot_blank;
    logic [3:0]           slot_anode;
    logic [6:0]           slot_seg;
    logic [6:0]           seg_q;
    logic [3:0]           anode_q;

    assign bcd_adj = dabble_adjust(bcd_q);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        units_d = units_q;
        tens_d  = tens_q;
        hund_d  = hund_q;
        done_d  = 1'b0;
        case (state_q)
            // Rising edge of load only: a strobe held across a conversion
            // must not retrigger once the FSM is back in IDLE.
            ST_IDLE: begin
                if (load && !load_q) begin
                    sr_d    = DataIn;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (cnt_q == CNT_W'(DATAWIDTH)) begin
                    state_d = ST_UPDATE;
                end else begin
                    bcd_d = (bcd_adj << 1) | BCD_W'(sr_q[DATAWIDTH-1]);
                    sr_d  = sr_q << 1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_UPDATE: begin
                units_d = bcd_q[3:0];
                tens_d  = bcd_q[7:4];
                hund_d  = bcd_q[11:8];
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            units_q <= '0;
            tens_q  <= '0;
            hund_q  <= '0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            hund_q  <= hund_d;
            done_q  <= done_d;
            load_q  <= load;
        end
    end

    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCANDIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    always_comb begin
        slot_digit = '0;
        slot_blank = 1'b1;
        slot_anode = 4'b1111;
        case (idx_q)
            2'd0: begin
                slot_digit = units_q;
                slot_blank = 1'b0;
                slot_anode = 4'b1110;
            end
            2'd1: begin
                slot_digit = tens_q;
                slot_blank = (hund_q == 4'd0) && (tens_q == 4'd0);
                slot_anode = 4'b1101;
            end
            2'd2: begin
                slot_digit = hund_q;
                slot_blank = (hund_q == 4'd0);
                slot_anode = 4'b1011;
            end
            default: ;
        endcase
    end

    bcd_to_seg7 u_seg (
        .digit_i (slot_digit),
        .blank_i (slot_blank),
        .seg_o   (slot_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_0;
            anode_q <= 4'b1110;
        end else begin
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= slot_seg;
            anode_q <= slot_blank ? 4'b1111 : slot_anode;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign sSeg   = seg_q;
    assign sAnode = anode_q;

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display (SCANDIV=4).
module tb_result_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] DataIn;
    logic       load;
    logic       busy, done;
    logic [6:0] sSeg;
    logic [3:0] sAnode;

    int checks   = 0;
    int failures = 0;

    int         w_hits [3];
    logic [6:0] w_seg  [3];
    int         w_blank, w_bad;
    int         lat;
    logic       busy_e0;

    result_display #(.DATAWIDTH(8), .SCANDIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .DataIn (DataIn),
        .load   (load),
        .busy   (busy),
        .done   (done),
        .sSeg   (sSeg),
        .sAnode (sAnode)
    );

    always #5 clk = ~clk;

    // One-cycle load pulse; lat = edges from the sampling edge to done (-1 = none within 30).
    task automatic pulse_load(input logic [7:0] v);
        @(negedge clk);
        DataIn = v;
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load    = 1'b0;
        busy_e0 = busy;
        lat     = done ? 0 : -1;
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) lat = k;
        end
    endtask

    // Tallies (anode, segment) pairs over one full 12-cycle scan period.
    task automatic scan_window();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            w_hits[i] = 0;
            w_seg[i]  = 7'bx;
        end
        w_blank = 0;
        w_bad   = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            case (sAnode)
                4'b1110: begin w_hits[0]++; w_seg[0] = sSeg; end
                4'b1101: begin w_hits[1]++; w_seg[1] = sSeg; end
                4'b1011: begin w_hits[2]++; w_seg[2] = sSeg; end
                4'b1111: if (sSeg == 7'b1111111) w_blank++; else w_bad++;
                default: w_bad++;
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; DataIn = '0;
        #12;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (sAnode !== 4'b1110) begin failures++; $display("FAIL reset_anode got=%b exp=1110", sAnode); end
        if (sSeg !== 7'b1000000) begin failures++; $display("FAIL reset_seg got=%b exp=1000000", sSeg); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_small();
        pulse_load(8'd6);
        scan_window();
        checks += 6;
        if (busy_e0 !== 1'b1) begin failures++; $display("FAIL small_busy got=%b exp=1", busy_e0); end
        if (lat != 10) begin failures++; $display("FAIL small_latency got=%0d exp=10", lat); end
        if (w_hits[0] != 4 || w_seg[0] !== 7'b0000010) begin
            failures++; $display("FAIL small_units hits=%0d seg=%b exp hits=4 seg=0000010", w_hits[0], w_seg[0]);
        end
        if (w_blank != 8) begin failures++; $display("FAIL small_blank got=%0d exp=8", w_blank); end
        if (w_bad != 0) begin failures++; $display("FAIL small_bad got=%0d exp=0", w_bad); end
        if (busy !== 1'b0) begin failures++; $display("FAIL small_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_max();
        pulse_load(8'd255);
        scan_window();
        checks += 5;
        if (lat != 10) begin failures++; $display("FAIL max_latency got=%0d exp=10", lat); end
        if (w_hits[2] != 4 || w_seg[2] !== 7'b0100100) begin
            failures++; $display("FAIL max_hund hits=%0d seg=%b exp hits=4 seg=0100100", w_hits[2], w_seg[2]);
        end
        if (w_hits[1] != 4 || w_seg[1] !== 7'b0010010) begin
            failures++; $display("FAIL max_tens hits=%0d seg=%b exp hits=4 seg=0010010", w_hits[1], w_seg[1]);
        end
        if (w_hits[0] != 4 || w_seg[0] !== 7'b0010010) begin
            failures++; $display("FAIL max_units hits=%0d seg=%b exp hits=4 seg=0010010", w_hits[0], w_seg[0]);
        end
        if (w_blank != 0 || w_bad != 0) begin
            failures++; $display("FAIL max_extra blank=%0d bad=%0d exp 0 0", w_blank, w_bad);
        end
    endtask

    task automatic test_scan();
        logic [3:0] a [24];
        logic [3:0] seq [3];
        int s, k, errs, a3;
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011;
        a3 = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            a[i] = sAnode;
            if (sAnode[3] !== 1'b1) a3++;
        end
        s = 1;
        while (s < 8 && a[s] == a[s-1]) s++;
        k = 0;
        for (int j = 0; j < 3; j++) if (a[s] == seq[j]) k = j;
        errs = 0;
        for (int j = 0; j < 12; j++)
            if (a[s+j] !== seq[(k + j/4) % 3]) errs++;
        checks += 2;
        if (errs != 0) begin failures++; $display("FAIL scan_sequence bad_samples=%0d exp=0 start=%b", errs, a[s]); end
        if (a3 != 0) begin failures++; $display("FAIL scan_anode3 low_samples=%0d exp=0", a3); end
    endtask

    task automatic test_zero_tens();
        pulse_load(8'd100);
        scan_window();
        checks += 4;
        if (lat != 10) begin failures++; $display("FAIL hund_latency got=%0d exp=10", lat); end
        if (w_seg[2] !== 7'b1111001) begin failures++; $display("FAIL hund_hund got=%b exp=1111001", w_seg[2]); end
        if (w_hits[1] != 4 || w_seg[1] !== 7'b1000000) begin
            failures++; $display("FAIL hund_tens hits=%0d seg=%b exp hits=4 seg=1000000", w_hits[1], w_seg[1]);
        end
        if (w_seg[0] !== 7'b1000000) begin failures++; $display("FAIL hund_units got=%b exp=1000000", w_seg[0]); end
    endtask

    task automatic test_held_load();
        int dones = 0;
        @(negedge clk);
        DataIn = 8'd7;
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        DataIn = 8'd9;
        for (int e = 1; e < 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        load = 1'b0;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            if (done) dones++;
        end
        scan_window();
        checks += 3;
        if (dones != 1) begin failures++; $display("FAIL held_done_count got=%0d exp=1", dones); end
        if (w_seg[0] !== 7'b1111000) begin failures++; $display("FAIL held_units got=%b exp=1111000", w_seg[0]); end
        if (w_blank != 8) begin failures++; $display("FAIL held_blank got=%0d exp=8", w_blank); end
    endtask

    task automatic test_load_while_busy();
        int dones = 0;
        @(negedge clk);
        DataIn = 8'd3;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        DataIn = 8'd8;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            if (done) dones++;
        end
        scan_window();
        checks += 2;
        if (dones != 1) begin failures++; $display("FAIL busy_load_done_count got=%0d exp=1", dones); end
        if (w_seg[0] !== 7'b0110000) begin failures++; $display("FAIL busy_load_units got=%b exp=0110000", w_seg[0]); end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        @(negedge clk);
        DataIn = 8'd255;
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (sAnode !== 4'b1110) begin failures++; $display("FAIL abort_anode got=%b exp=1110", sAnode); end
        if (sSeg !== 7'b1000000) begin failures++; $display("FAIL abort_seg got=%b exp=1000000", sSeg); end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks += 1;
        if (dones != 0) begin failures++; $display("FAIL abort_done_count got=%0d exp=0", dones); end
        pulse_load(8'd42);
        scan_window();
        checks += 4;
        if (lat != 10) begin failures++; $display("FAIL after_abort_latency got=%0d exp=10", lat); end
        if (w_seg[1] !== 7'b0011001) begin failures++; $display("FAIL after_abort_tens got=%b exp=0011001", w_seg[1]); end
        if (w_seg[0] !== 7'b0100100) begin failures++; $display("FAIL after_abort_units got=%b exp=0100100", w_seg[0]); end
        if (w_blank != 4) begin failures++; $display("FAIL after_abort_blank got=%0d exp=4", w_blank); end
    endtask

    initial begin
        test_reset();
        test_small();
        test_max();
        test_scan();
        test_zero_tens();
        test_held_load();
        test_load_while_busy();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, width of the binary result consumed.
REQ-002 SHALL have parameter SCANDIV, default 12500, clk cycles per digit slot of the display scan.
REQ-003 SHALL have port clk, input, 1, system clock; single clock domain.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port DataIn, input, DATAWIDTH, binary result taken from the datapath result register (register 0).
REQ-006 SHALL have port load, input, 1, active-high capture strobe.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when the display digits update.
REQ-009 SHALL have port sSeg, output, 7, segments gfedcba, active-low.
REQ-010 SHALL have port sAnode, output, 4, digit enables, active-low; bit 0 = units.

Function
REQ-011 SHALL implement FSM with states IDLE, CONVERT and UPDATE.
REQ-012 In IDLE with load=1 at an edge, SHALL capture DataIn into the shift register, clear the 12-bit BCD accumulator and iteration count, and go to CONVERT.
REQ-013 In CONVERT, SHALL per cycle add 3 to each BCD nibble >= 5, then shift {BCD, shift register} left by one bit (double-dabble).
REQ-014 SHALL leave CONVERT for UPDATE after exactly DATAWIDTH shifts.
REQ-015 In UPDATE, SHALL copy the BCD nibbles to the display digit registers (units, tens, hundreds), pulse done for one cycle, and return to IDLE.
REQ-016 Latency: the display registers and done SHALL change on the 10th edge after the edge sampling load, for DATAWIDTH=8.
REQ-017 busy SHALL be high in CONVERT and UPDATE and low in IDLE.
REQ-018 load asserted while not in IDLE SHALL be ignored, not queued.
REQ-019 DataIn changes after capture SHALL NOT affect the conversion in progress.
REQ-020 The scan counter SHALL count 0..SCANDIV-1 and wrap; each wrap SHALL advance the digit index 0->1->2->0.
REQ-021 The scan SHALL run continuously, independent of the FSM.
REQ-022 The active index SHALL drive its anode low and all others high; sAnode[3] SHALL always be 1.
REQ-023 Segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 Leading-zero blanking: hundreds SHALL be blanked when 0; tens SHALL be blanked when hundreds=0 and tens=0; units SHALL never be blanked.
REQ-025 A blanked slot SHALL drive its anode high and sSeg=1111111.
REQ-026 sSeg and sAnode SHALL be registered outputs, with no combinational path from DataIn or load.

Reset
REQ-027 On rst=1, asynchronously: FSM=IDLE, busy=0, done=0, digit registers=0, scan counter=0, index=0, sAnode=1110, sSeg=1000000 (units "0").
REQ-028 Reset during CONVERT or UPDATE SHALL abort the conversion with no done pulse, and the display SHALL show "0".
REQ-029 The first load after rst deasserts SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the ten segment constants and SEG_BLANK.
REQ-031 Sub-module bcd_to_seg7 SHALL be combinational: 4-bit digit plus blank flag in, 7-bit sSeg out; codes 10-15 SHALL map to SEG_BLANK.
REQ-032 Scan counter, FSM and datapath SHALL reside in result_display.

Verification (SCANDIV=4)
REQ-033 DataIn=6, load pulse -> done exactly 10 edges later; units slot shows 0000010; tens and hundreds slots blanked (anodes high).
REQ-034 DataIn=255 -> digits 2,5,5; segments 0100100, 0010010, 0010010 across the three scan slots.
REQ-035 DataIn=100 -> hundreds 1111001, tens 1000000 (not blanked), units 1000000.
REQ-036 load=1 held for 12 cycles with DataIn changing from 7 to 9 after the first edge -> exactly one done pulse; display shows 7.
REQ-037 rst asserted on the 4th CONVERT cycle of DataIn=255 -> no done pulse; sAnode=1110, sSeg=1000000; a subsequent load of 42 shows "42".
REQ-038 Free-running scan -> sAnode sequence 1110, 1101, 1011, repeating every 12 cycles; sAnode[3] never 0.
